// File: rtl/derandomizer.sv
// Receive-side 802.16 PRBS (1 + x^14 + x^15) derandomizer with ready/valid on both sides.
// One W-bit beat per cycle; the PRBS is unrolled W steps and advances only on an accepted beat.
module derandomizer #(
    parameter int unsigned W     = 8,
    parameter int unsigned LEN_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_burst_start,
    input  logic [14:0]      i_seed,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic [W-1:0]     i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [W-1:0]     o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_err_len
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             r_state;
    logic [14:0]        r_vect;
    logic [LEN_W-1:0]   r_count;
    logic               r_out_valid;
    logic [W-1:0]       r_out_data;
    logic               r_out_last;
    logic               r_err_len;

    state_e             w_state_nxt;
    logic [14:0]        w_vect_nxt;
    logic [LEN_W-1:0]   w_count_nxt;
    logic               w_out_valid_nxt;
    logic [W-1:0]       w_out_data_nxt;
    logic               w_out_last_nxt;
    logic               w_err_len_nxt;

    logic [14:0]        w_vect_adv;
    logic [W-1:0]       w_ks;
    logic               w_accept;
    logic               w_len_zero;
    logic               w_last_beat;

    // Keystream bit for in_data[W-1] comes from the first serial step.
    always_comb begin
        w_vect_adv = r_vect;
        w_ks       = '0;
        for (int unsigned i = 0; i < W; i++) begin
            w_ks[W-1-i] = w_vect_adv[14] ^ w_vect_adv[13];
            w_vect_adv  = {w_vect_adv[13:0], w_ks[W-1-i]};
        end
    end

    assign o_in_ready  = (r_state == StRun) & ~i_burst_start & (~r_out_valid | i_out_ready);
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_len_zero  = (i_burst_len == '0);
    assign w_last_beat = (r_count == LEN_W'(1));

    always_comb begin
        w_state_nxt   = r_state;
        w_vect_nxt    = r_vect;
        w_count_nxt   = r_count;
        w_err_len_nxt = r_err_len;
        unique case (r_state)
            StIdle: begin
                if (i_burst_start) begin
                    if (w_len_zero) begin
                        w_err_len_nxt = 1'b1;
                    end else begin
                        w_state_nxt = StRun;
                        w_vect_nxt  = i_seed;
                        w_count_nxt = i_burst_len;
                    end
                end
            end
            StRun: begin
                // A restart mid-burst is an abort: reload and flag, never accept that cycle.
                if (i_burst_start) begin
                    w_err_len_nxt = 1'b1;
                    w_vect_nxt    = i_seed;
                    w_count_nxt   = i_burst_len;
                    w_state_nxt   = w_len_zero ? StIdle : StRun;
                end else if (w_accept) begin
                    w_vect_nxt  = w_vect_adv;
                    w_count_nxt = r_count - LEN_W'(1);
                    if (w_last_beat) begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = i_in_data ^ w_ks;
            w_out_last_nxt  = w_last_beat;
        end else if (i_out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_vect      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vect      <= w_vect_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_err_len   <= w_err_len_nxt;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state == StRun);
    assign o_err_len   = r_err_len;

endmodule

// File: tb/tb_derandomizer.sv
// Self-checking bench for derandomizer (W=8): cycle model from the burst/handshake rules,
// serial PRBS reference, directed vectors and a randomized round trip.
module tb_derandomizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        burst_start;
    logic [14:0] seed;
    logic [11:0] burst_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        err_len;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    logic [8:0] rx_q[$];

    always #5 clk = ~clk;

    derandomizer #(.W(8), .LEN_W(12)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_burst_start (burst_start),
        .i_seed        (seed),
        .i_burst_len   (burst_len),
        .i_in_data     (in_data),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_last    (out_last),
        .o_busy        (busy),
        .o_err_len     (err_len)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial reference: 8 feedback bits, first one lands on bit 7.
    function automatic logic [7:0] prbs_ks(input logic [14:0] v);
        logic fb;
        logic [7:0] k;
        k = '0;
        for (int s = 0; s < 8; s++) begin
            fb       = v[14] ^ v[13];
            k[7 - s] = fb;
            v        = {v[13:0], fb};
        end
        return k;
    endfunction

    function automatic logic [14:0] prbs_adv(input logic [14:0] v);
        for (int s = 0; s < 8; s++) v = {v[13:0], v[14] ^ v[13]};
        return v;
    endfunction

    // Behavioural model of the burst and output register.
    logic        m_run, m_ov, m_ol, m_err;
    logic [14:0] m_vect;
    int          m_count;
    logic [7:0]  m_od;
    logic        m_rdy, m_acc;

    assign m_rdy = m_run && !burst_start && (!m_ov || out_ready);
    assign m_acc = m_rdy && in_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_ov <= 1'b0; m_ol <= 1'b0; m_err <= 1'b0;
            m_vect <= '0; m_count <= 0; m_od <= '0;
        end else begin
            if (m_acc) begin
                m_ov <= 1'b1;
                m_od <= in_data ^ prbs_ks(m_vect);
                m_ol <= (m_count == 1);
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
            if (burst_start) begin
                if (m_run || burst_len == 0) m_err <= 1'b1;
                m_vect  <= seed;
                m_count <= int'(burst_len);
                m_run   <= (burst_len != 0);
            end else if (m_acc) begin
                m_vect  <= prbs_adv(m_vect);
                m_count <= m_count - 1;
                if (m_count == 1) m_run <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("in_ready", in_ready, m_rdy);
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, m_run);
            chk("err_len", err_len, m_err);
            if (m_ov) begin
                chk("out_data", out_data, m_od);
                chk("out_last", out_last, m_ol);
            end
            if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [14:0] s, input logic [11:0] len);
        burst_start = 1'b1;
        seed        = s;
        burst_len   = len;
        idle(1);
        burst_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("send_accept", in_ready, 1);
        idle(1);
        in_valid = 1'b0;
    endtask

    task automatic vec_6000(input string tag);
        rx_q.delete();
        pulse_start(15'h6000, 12'd2);
        send(8'h00);
        send(8'hFF);
        idle(3);
        chk({tag, "_cnt"}, rx_q.size(), 2);
        chk({tag, "_b0"}, rx_q[0], 9'h040);
        chk({tag, "_b1"}, rx_q[1], 9'h1FE);
        chk({tag, "_busy"}, busy, 0);
    endtask

    logic [7:0]  orig[200];
    logic [7:0]  rnd[200];
    logic [14:0] v;
    int ti, ri, cyc;

    initial begin
        rst = 1'b1; burst_start = 1'b0; seed = '0; burst_len = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        idle(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_len, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(1);

        vec_6000("v1");

        // Output stalled with a beat held: input side must close and the PRBS must not move.
        rx_q.delete();
        pulse_start(15'h1234, 12'd6);
        send(8'h11);
        send(8'h22);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        idle(1);
        out_ready = 1'b1;
        send(8'h33);
        send(8'h44);
        send(8'h55);
        send(8'h66);
        idle(3);
        chk("bp_cnt", rx_q.size(), 6);
        chk("bp_last5", rx_q[5][8], 1);
        chk("bp_last4", rx_q[4][8], 0);

        // Round trip through a bench-side randomizer with the same seed.
        v = 15'h2A5B;
        for (int i = 0; i < 200; i++) begin
            orig[i] = 8'($urandom);
            rnd[i]  = orig[i] ^ prbs_ks(v);
            v       = prbs_adv(v);
        end
        pulse_start(15'h2A5B, 12'd200);
        ti = 0; ri = 0; cyc = 0;
        while (ri < 200 && cyc < 5000) begin
            in_valid  = (ti < 200) && ($urandom_range(0, 3) != 0);
            in_data   = (ti < 200) ? rnd[ti] : 8'h00;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) ti++;
            if (out_valid && out_ready) begin
                chk("rt_data", out_data, orig[ri]);
                chk("rt_last", out_last, (ri == 199));
                ri++;
            end
            idle(1);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rt_count", ri, 200);
        idle(2);
        chk("rt_err", err_len, 0);

        // Zero-length burst from idle.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        pulse_start(15'h1111, 12'd0);
        repeat (3) begin
            @(negedge clk);
            chk("len0_busy", busy, 0);
            chk("len0_in_ready", in_ready, 0);
            chk("len0_err", err_len, 1);
        end
        idle(1);
        in_valid = 1'b0;

        // Abort on the 3rd beat of 4, previous beat still held in the output register.
        rx_q.delete();
        pulse_start(15'h0BCD, 12'd4);
        send(8'h01);
        send(8'h02);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'h5A;
        burst_start = 1'b1;
        seed        = 15'h4000;
        burst_len   = 12'd1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 0);
        idle(1);
        burst_start = 1'b0;
        out_ready   = 1'b1;
        send(8'h5A);
        idle(3);
        chk("abort_cnt", rx_q.size(), 3);
        chk("abort_b1_last", rx_q[1][8], 0);
        chk("abort_b2", rx_q[2], 9'h1DA);
        chk("abort_err", err_len, 1);
        chk("abort_busy", busy, 0);

        // Asynchronous reset while a beat is held.
        pulse_start(15'h7FFF, 12'd5);
        out_ready = 1'b0;
        send(8'hC3);
        #1;
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_len, 0);
        chk("arst_in_ready", in_ready, 0);
        idle(1);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(1);
        vec_6000("v2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
